qnigma_tcp_ack_sched: RTL and testbench

- Schedules pure-ACK transmissions for the TCP receive path.
- Watches the local acknowledgement number and SACK option produced by the receive/SACK logic and decides when an ACK must go out: delayed, every Nth segment, immediately on out-of-order arrival, or on force.
- Presents a latched ACK/SACK snapshot to the TCP transmit engine through a req/acc handshake.

---
 rtl/qnigma_pkg.sv | 25 ++
 rtl/qnigma_tcp_ack_timer.sv | 25 ++
 rtl/qnigma_tcp_ack_sched.sv | 131 +++++++++++++
 tb/tb_qnigma_tcp_ack_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qnigma_pkg.sv
// Shared TCP types and constants for the qnigma stack.
// Holds the SACK option layout and the ACK scheduler defaults and state encoding.
package qnigma_pkg;

  localparam int TCP_ACK_DELAY_TICKS = 12500000;
  localparam int TCP_ACK_SEG_THRESH  = 2;
  localparam int TCP_SACK_BLOCKS     = 4;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } tcp_sack_blk_t;

  typedef struct packed {
    tcp_sack_blk_t [TCP_SACK_BLOCKS-1:0] blk;
    logic          [TCP_SACK_BLOCKS-1:0] val;
  } tcp_opt_sack_t;

  typedef enum logic [1:0] {
    IDLE,
    DLY,
    REQ
  } ack_sched_state_t;

endpackage

// File: rtl/qnigma_tcp_ack_timer.sv
// Load/clear/enable down-counter; expired is high while enabled and at zero.
// Shared by the ACK delay, retransmit and keepalive timers.
module qnigma_tcp_ack_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr)            cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/qnigma_tcp_ack_sched.sv
// Pure-ACK scheduler: decides when the receive path owes the peer an ACK and
// hands a latched ACK/SACK snapshot to the transmit engine via ack_req/ack_acc.
module qnigma_tcp_ack_sched
  import qnigma_pkg::*;
#(
  parameter int ACK_DELAY_TICKS = TCP_ACK_DELAY_TICKS,
  parameter int SEG_THRESH      = TCP_ACK_SEG_THRESH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ini,
  input  logic          connected,
  input  logic [31:0]   tcb_loc_ack,
  input  logic [31:0]   loc_ack,
  input  tcp_opt_sack_t sack,
  input  logic          force_ack,
  output logic          ack_req,
  input  logic          ack_acc,
  output logic [31:0]   ack_num,
  output tcp_opt_sack_t ack_sack,
  output logic [15:0]   ack_cnt
);

  localparam int TW = $clog2(ACK_DELAY_TICKS);
  localparam int SW = $clog2(SEG_THRESH + 1);
  localparam logic [SW-1:0] SEG_MAX = SW'(SEG_THRESH);

  ack_sched_state_t state, state_nxt;
  logic [31:0]      loc_ack_q, sent_ack;
  tcp_opt_sack_t    sack_q;
  logic [SW-1:0]    seg_ctr, seg_inc;
  logic adv, sack_chg, pending, imm, seg_hit, acc, snap;
  logic re_arm_adv, re_arm_imm;
  logic tmr_load, tmr_clr, tmr_en, tmr_exp;

  assign adv      = (loc_ack != loc_ack_q);
  assign sack_chg = (sack != sack_q);
  assign pending  = (loc_ack != sent_ack);
  assign imm      = force_ack | sack_chg;
  assign seg_inc  = (seg_ctr == SEG_MAX) ? seg_ctr : seg_ctr + SW'(1);
  assign seg_hit  = adv && (seg_inc == SEG_MAX);
  assign acc      = (state == REQ) && ack_req && ack_acc && connected && !ini;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (imm || seg_hit)      state_nxt = REQ;
        else if (adv || pending) state_nxt = DLY;
      end
      DLY: begin
        if (imm || seg_hit || seg_ctr == SEG_MAX || tmr_exp) state_nxt = REQ;
      end
      REQ: begin
        if (acc) begin
          if (re_arm_imm || imm)                                 state_nxt = REQ;
          else if (re_arm_adv || adv || loc_ack != ack_num)      state_nxt = DLY;
          else                                                   state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (ini || !connected) state_nxt = IDLE;
  end

  // A REQ with ack_req low is the one-cycle gap after an immediate re-arm.
  assign snap = (state_nxt == REQ) && !acc && !((state == REQ) && ack_req);

  assign tmr_en   = (state == DLY);
  assign tmr_load = (state_nxt == DLY) && (state != DLY);
  assign tmr_clr  = (state_nxt != DLY);

  qnigma_tcp_ack_timer #(
    .W (TW)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (TW'(ACK_DELAY_TICKS - 1)),
    .en       (tmr_en),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      loc_ack_q  <= '0;
      sack_q     <= '0;
      sent_ack   <= '0;
      ack_req    <= 1'b0;
      ack_num    <= '0;
      ack_sack   <= '0;
      ack_cnt    <= '0;
      seg_ctr    <= '0;
      re_arm_adv <= 1'b0;
      re_arm_imm <= 1'b0;
    end else begin
      state     <= state_nxt;
      loc_ack_q <= ini ? tcb_loc_ack : loc_ack;
      sack_q    <= sack;

      if (ini)      sent_ack <= tcb_loc_ack;
      else if (acc) sent_ack <= ack_num;

      if (ini || !connected || acc) ack_req <= 1'b0;
      else if (snap)                ack_req <= 1'b1;

      if (snap) begin
        ack_num  <= loc_ack;
        ack_sack <= sack;
      end

      if (acc) ack_cnt <= ack_cnt + 16'd1;

      // An advance coinciding with the accept is the first of the next batch.
      if (ini || !connected)        seg_ctr <= '0;
      else if (acc)                 seg_ctr <= adv ? SW'(1) : '0;
      else if (state != REQ && adv) seg_ctr <= seg_inc;

      if (state_nxt != REQ || snap || acc) begin
        re_arm_adv <= 1'b0;
        re_arm_imm <= 1'b0;
      end else begin
        re_arm_adv <= re_arm_adv | adv;
        re_arm_imm <= re_arm_imm | imm;
      end
    end
  end

endmodule

// File: tb/tb_qnigma_tcp_ack_sched.sv
// Directed and randomized checks of the ACK scheduler against latencies and
// snapshot values derived from its timing rules.
module tb_qnigma_tcp_ack_sched;
  import qnigma_pkg::*;

  localparam int D = 16;
  localparam int T = 2;

  typedef logic [$bits(tcp_opt_sack_t)-1:0] wide_t;

  logic          clk = 1'b0;
  logic          rst, ini, connected, force_ack, ack_acc;
  logic [31:0]   tcb_loc_ack, loc_ack;
  tcp_opt_sack_t sack;
  logic          ack_req;
  logic [31:0]   ack_num;
  tcp_opt_sack_t ack_sack;
  logic [15:0]   ack_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  qnigma_tcp_ack_sched #(
    .ACK_DELAY_TICKS (D),
    .SEG_THRESH      (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ini         (ini),
    .connected   (connected),
    .tcb_loc_ack (tcb_loc_ack),
    .loc_ack     (loc_ack),
    .sack        (sack),
    .force_ack   (force_ack),
    .ack_req     (ack_req),
    .ack_acc     (ack_acc),
    .ack_num     (ack_num),
    .ack_sack    (ack_sack),
    .ack_cnt     (ack_cnt)
  );

  always #5 clk = ~clk;

  // One clock: inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ini       = 1'b0;
    force_ack = 1'b0;
    ack_acc   = 1'b0;
  endtask

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the current (driven) cycle until ack_req is seen high.
  task automatic wait_req(input int limit, output int k);
    k = 0;
    while (ack_req !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
  endtask

  // Model state: the count of accepted ACKs and the current peer-visible values.
  int          exp_cnt;
  logic [31:0] cur;
  tcp_opt_sack_t sk;

  task automatic accept(input string tag);
    ack_acc = 1'b1;
    tick();
    exp_cnt++;
    chk({tag, "_req_low"}, wide_t'(ack_req), wide_t'(1'b0));
    chk({tag, "_cnt"}, wide_t'(ack_cnt), wide_t'(16'(exp_cnt)));
  endtask

  initial begin
    int k, g, mode;
    rst = 1'b0; ini = 1'b0; connected = 1'b1; force_ack = 1'b0; ack_acc = 1'b0;
    tcb_loc_ack = '0; loc_ack = '0; sack = '0; sk = '0; exp_cnt = 0;
    #1;
    repeat (3) tick();
    chk("rst_req",   wide_t'(ack_req),  wide_t'(1'b0));
    chk("rst_num",   wide_t'(ack_num),  wide_t'(32'h0));
    chk("rst_sack",  wide_t'(ack_sack), wide_t'(0));
    chk("rst_cnt",   wide_t'(ack_cnt),  wide_t'(16'h0));
    chk("rst_state", wide_t'(dut.state), wide_t'(IDLE));

    // Single advance: delayed ACK after ACK_DELAY_TICKS+1 cycles.
    rst = 1'b1; loc_ack = 32'h1000; tcb_loc_ack = 32'h1000; ini = 1'b1;
    tick();
    loc_ack = 32'h1200;
    wait_req(D + 8, k);
    chk("t1_lat", wide_t'(k), wide_t'(D + 1));
    chk("t1_num", wide_t'(ack_num), wide_t'(32'h1200));
    accept("t1");
    chk("t1_state", wide_t'(dut.state), wide_t'(IDLE));

    // Two advances reach the segment threshold.
    loc_ack = 32'h1000; tcb_loc_ack = 32'h1000; ini = 1'b1;
    tick();
    loc_ack = 32'h1200;
    repeat (3) tick();
    chk("t2_no_req", wide_t'(ack_req), wide_t'(1'b0));
    loc_ack = 32'h1400;
    wait_req(D + 8, k);
    chk("t2_lat", wide_t'(k), wide_t'(1));
    chk("t2_num", wide_t'(ack_num), wide_t'(32'h1400));
    accept("t2");

    // SACK change alone is immediate.
    sk.blk[3].left = 32'h2000; sk.blk[3].right = 32'h2400; sk.val[3] = 1'b1;
    sack = sk;
    wait_req(D + 8, k);
    chk("t3_lat",  wide_t'(k), wide_t'(1));
    chk("t3_sack", wide_t'(ack_sack), wide_t'(sk));
    chk("t3_num",  wide_t'(ack_num), wide_t'(32'h1400));
    accept("t3");
    chk("t3_state", wide_t'(dut.state), wide_t'(IDLE));

    // Advance while REQ is held: snapshot stable, then a delayed second ACK.
    force_ack = 1'b1;
    wait_req(D + 8, k);
    chk("t4_lat", wide_t'(k), wide_t'(1));
    loc_ack = 32'h1600;
    repeat (10) tick();
    chk("t4_hold_req",  wide_t'(ack_req),  wide_t'(1'b1));
    chk("t4_hold_num",  wide_t'(ack_num),  wide_t'(32'h1400));
    chk("t4_hold_sack", wide_t'(ack_sack), wide_t'(sk));
    accept("t4");
    chk("t4_state", wide_t'(dut.state), wide_t'(DLY));
    wait_req(D + 8, k);
    chk("t4_lat2", wide_t'(k), wide_t'(D));
    chk("t4_num2", wide_t'(ack_num), wide_t'(32'h1600));
    accept("t4b");

    // Accept and advance together: the advance counts as the first segment.
    force_ack = 1'b1;
    wait_req(D + 8, k);
    loc_ack = 32'h1700;
    accept("t5");
    chk("t5_state", wide_t'(dut.state), wide_t'(DLY));
    repeat (2) tick();
    loc_ack = 32'h1800;
    wait_req(D + 8, k);
    chk("t5_lat", wide_t'(k), wide_t'(1));
    chk("t5_num", wide_t'(ack_num), wide_t'(32'h1800));
    accept("t5b");

    // Force during REQ re-requests one cycle after the fall.
    force_ack = 1'b1;
    wait_req(D + 8, k);
    force_ack = 1'b1;
    tick();
    accept("t6");
    tick();
    chk("t6_rearm", wide_t'(ack_req), wide_t'(1'b1));
    accept("t6b");
    chk("t6_state", wide_t'(dut.state), wide_t'(IDLE));

    // Randomized: single delayed advance, double advance, or SACK change.
    cur = 32'h1800;
    for (int it = 0; it < 16; it++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        cur = cur + $urandom_range(1, 65535);
        loc_ack = cur;
        wait_req(D + 8, k);
        chk("rnd_single_lat", wide_t'(k), wide_t'(D + 1));
      end else if (mode == 1) begin
        g = int'($urandom_range(1, D - 1));
        cur = cur + $urandom_range(1, 65535);
        loc_ack = cur;
        repeat (g) tick();
        cur = cur + $urandom_range(1, 65535);
        loc_ack = cur;
        wait_req(D + 8, k);
        chk("rnd_double_lat", wide_t'(k), wide_t'(1));
      end else begin
        sk.blk[0].left  = sk.blk[0].left + $urandom_range(1, 1000);
        sk.blk[0].right = sk.blk[0].left + 32'h100;
        sk.val[0]       = 1'b1;
        sack = sk;
        wait_req(D + 8, k);
        chk("rnd_sack_lat", wide_t'(k), wide_t'(1));
      end
      chk("rnd_num",  wide_t'(ack_num),  wide_t'(cur));
      chk("rnd_sack", wide_t'(ack_sack), wide_t'(sk));
      accept("rnd");
      chk("rnd_state", wide_t'(dut.state), wide_t'(IDLE));
    end

    // Connection drop abandons a pending request.
    force_ack = 1'b1;
    wait_req(D + 8, k);
    chk("t7_req", wide_t'(ack_req), wide_t'(1'b1));
    connected = 1'b0;
    tick();
    chk("t7_drop_req", wide_t'(ack_req), wide_t'(1'b0));
    chk("t7_drop_cnt", wide_t'(ack_cnt), wide_t'(16'(exp_cnt)));
    ack_acc = 1'b1;
    tick();
    chk("t7_late_acc_cnt", wide_t'(ack_cnt), wide_t'(16'(exp_cnt)));
    connected = 1'b1;
    tick();
    chk("t7_state", wide_t'(dut.state), wide_t'(IDLE));

    // Sequence-number wrap is still an advance.
    loc_ack = 32'hFFFF_FF00; tcb_loc_ack = 32'hFFFF_FF00; ini = 1'b1;
    tick();
    loc_ack = 32'h0000_0100;
    wait_req(D + 8, k);
    chk("t8_lat", wide_t'(k), wide_t'(D + 1));
    chk("t8_num", wide_t'(ack_num), wide_t'(32'h0000_0100));
    accept("t8");

    // Reset in the middle of a delay clears every output.
    loc_ack = 32'h0000_0200;
    repeat (3) tick();
    chk("t9_dly", wide_t'(dut.state), wide_t'(DLY));
    rst = 1'b0;
    tick();
    chk("t9_req",  wide_t'(ack_req),  wide_t'(1'b0));
    chk("t9_num",  wide_t'(ack_num),  wide_t'(32'h0));
    chk("t9_sack", wide_t'(ack_sack), wide_t'(0));
    chk("t9_cnt",  wide_t'(ack_cnt),  wide_t'(16'h0));
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
